// File: rtl/timer_scheduler_if.sv
// Request/grant bundle between client FSMs and the shared timer scheduler.
// The scheduler side is the slave; the clients (or a bench) drive the master side.
interface timer_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int W       = 16,
  parameter int IDX_W   = $clog2(NUM_REQ)
) ();
  logic [NUM_REQ-1:0]   req_i;
  logic [NUM_REQ*W-1:0] n_i;
  logic [NUM_REQ-1:0]   grant_q;
  logic [IDX_W-1:0]     grant_idx_q;
  logic                 busy_q;
  logic [W-1:0]         curr_time_q;
  logic [NUM_REQ-1:0]   done_q;
  logic [NUM_REQ-1:0]   abort_q;

  modport master (
    output req_i, n_i,
    input  grant_q, grant_idx_q, busy_q, curr_time_q, done_q, abort_q
  );

  modport slave (
    input  req_i, n_i,
    output grant_q, grant_idx_q, busy_q, curr_time_q, done_q, abort_q
  );
endinterface

// File: rtl/timer_scheduler.sv
// Round-robin owner of a single elapsed-time counter shared by NUM_REQ clients.
// A grant latches the client's duration, counts it out, then pulses done (or abort).
module timer_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int W       = 16,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  timer_scheduler_if.slave   bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [W-1:0]       n_lat;
  logic [NUM_REQ-1:0] elig;
  logic [IDX_W-1:0]   pick;
  logic [IDX_W-1:0]   cand;
  logic               pick_vld;
  logic [W-1:0]       n_pick;
  int                 sum;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] k);
    onehot    = '0;
    onehot[k] = 1'b1;
  endfunction

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] k);
    wrap_inc = (int'(k) == NUM_REQ - 1) ? '0 : k + 1'b1;
  endfunction

  // A client whose pulse is showing this cycle is masked so it can see it before re-arbitration.
  always_comb begin
    elig     = bus.req_i & ~(bus.done_q | bus.abort_q);
    pick     = '0;
    pick_vld = 1'b0;
    sum      = 0;
    cand     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = int'(ptr) + i;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      cand = IDX_W'(sum);
      if (!pick_vld && elig[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
    n_pick = bus.n_i[int'(pick)*W +: W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      ptr             <= '0;
      n_lat           <= '0;
      bus.grant_q     <= '0;
      bus.grant_idx_q <= '0;
      bus.busy_q      <= 1'b0;
      bus.curr_time_q <= '0;
      bus.done_q      <= '0;
      bus.abort_q     <= '0;
    end else begin
      bus.done_q  <= '0;
      bus.abort_q <= '0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            bus.grant_idx_q <= pick;
            n_lat           <= n_pick;
            bus.curr_time_q <= '0;
            ptr             <= wrap_inc(pick);
            // A zero duration completes immediately without ever owning the counter.
            if (n_pick == '0) begin
              bus.done_q <= onehot(pick);
            end else begin
              bus.grant_q <= onehot(pick);
              bus.busy_q  <= 1'b1;
              state       <= RUN;
            end
          end
        end
        RUN: begin
          if (!bus.req_i[bus.grant_idx_q]) begin
            bus.abort_q     <= bus.grant_q;
            bus.grant_q     <= '0;
            bus.busy_q      <= 1'b0;
            bus.curr_time_q <= '0;
            state           <= IDLE;
          end else if (bus.curr_time_q == n_lat - 1'b1) begin
            bus.done_q      <= bus.grant_q;
            bus.grant_q     <= '0;
            bus.busy_q      <= 1'b0;
            bus.curr_time_q <= '0;
            state           <= IDLE;
          end else begin
            bus.curr_time_q <= bus.curr_time_q + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
